// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU button tracker.
package lru_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    RELEASE
  } state_t;

  localparam int MAX_CH   = 15;
  localparam int MAX_ID_W = 4;

  localparam logic [MAX_ID_W-1:0] EMPTY_ID = '0;

  // Lowest set bit wins; bit k maps to channel ID k+1, no bits set gives EMPTY_ID.
  function automatic logic [MAX_ID_W-1:0] winner_id(input logic [MAX_CH-1:0] bits);
    logic [MAX_ID_W-1:0] id;
    id = EMPTY_ID;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (bits[i]) id = MAX_ID_W'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/lru_tick_gen.sv
// Sampling tick generator: a one-cycle clock enable every TICK_DIV cycles.
module lru_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  generate
    if (TICK_DIV <= 1) begin : g_every
      logic unused_ports;
      assign unused_ports = clk ^ rst;
      assign tick = 1'b1;
    end else begin : g_div
      localparam int CNT_W = $clog2(TICK_DIV);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

      logic [CNT_W-1:0] cnt;

      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign tick = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/lru_tracker.sv
// Least-recently-used tracker: ordered queue of the DEPTH most recently
// pressed distinct button channels, MRU in slot 0, with eviction reporting.
module lru_tracker
  import lru_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int DEPTH    = 3,
  parameter  int TICK_DIV = 50_000_000,
  localparam int ID_W     = $clog2(N_CH + 1),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  btn,
  output logic [N_CH-1:0]  led,
  output logic [ID_W-1:0]  mru_id,
  output logic [ID_W-1:0]  lru_id,
  output logic [CNT_W-1:0] count,
  output logic             evict_valid,
  output logic [ID_W-1:0]  evict_id
);

  localparam logic [ID_W-1:0] NONE = ID_W'(EMPTY_ID);

  state_t          state;
  state_t          state_next;
  logic            tick;
  logic            sample;
  logic            apply;
  logic [ID_W-1:0] win;

  logic [ID_W-1:0] q      [DEPTH];
  logic [ID_W-1:0] q_next [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [DEPTH:0]   seen;
  logic             evict_next;

  lru_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: a default assignment at the top of every always_comb keeps
  // paths that skip an assignment from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick && (|btn)) state_next = UPDATE;
      UPDATE:  state_next = RELEASE;
      RELEASE: if (tick && !(|btn)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sample = (state == IDLE) && tick && (|btn);
    apply  = (state == UPDATE);
  end

  // Slot j takes slot j-1 until the shift reaches the slot that held the
  // winner; slots past that point keep their contents.
  assign seen[0] = 1'b0;
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    assign hit[j]    = (q[j] == win);
    assign seen[j+1] = seen[j] | hit[j];
    if (j == 0) begin : g_head
      assign q_next[j] = win;
    end else begin : g_tail
      assign q_next[j] = seen[j] ? q[j] : q[j-1];
    end
  end

  assign evict_next = !seen[DEPTH] && (q[DEPTH-1] != NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      win         <= NONE;
      evict_valid <= 1'b0;
      evict_id    <= NONE;
      // NOTE: the queue is a handful of flops, not a RAM, and its contents
      // are architecturally visible, so every slot is reset.
      for (int j = 0; j < DEPTH; j++) q[j] <= NONE;
    end else begin
      if (sample) win <= ID_W'(winner_id(MAX_CH'(btn)));
      evict_valid <= apply && evict_next;
      evict_id    <= (apply && evict_next) ? q[DEPTH-1] : NONE;
      if (apply) begin
        for (int j = 0; j < DEPTH; j++) q[j] <= q_next[j];
      end
    end
  end

  assign mru_id = q[0];

  always_comb begin
    led    = '0;
    lru_id = NONE;
    count  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (q[j] != NONE) begin
        lru_id = q[j];
        count  = CNT_W'(j + 1);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (q[j] == ID_W'(k + 1)) led[k] = 1'b1;
      end
    end
  end

endmodule

// File: doc/lru_tracker.md
# lru_tracker

Parametrised least-recently-used tracker for N_CH push-button channels. It keeps an ordered queue of the DEPTH most recently pressed distinct channels, most recent first. A re-pressed channel moves to the front without duplication, and the least recent entry is evicted on overflow. It sits between the board button inputs and the status LEDs, and exports MRU/LRU identities and eviction events for downstream logic.

## Interface
- N_CH, default 4: number of button/LED channels, 2..15.
- DEPTH, default 3: queue slots, 1..N_CH.
- TICK_DIV, default 50_000_000: clock cycles per sampling tick, ≥1; 1 samples every cycle.
- Derived ID_W = $clog2(N_CH+1): channel ID width; ID 0 = empty, IDs 1..N_CH = channels.
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- btn  in  N_CH  button levels; bit k is channel ID k+1.
- led  out  N_CH  bit k high iff channel k+1 is in the queue.
- mru_id  out  ID_W  ID in slot 0; 0 when empty.
- lru_id  out  ID_W  ID in the last occupied slot; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of occupied slots.
- evict_valid  out  1  one-cycle pulse when an entry is dropped off the tail.
- evict_id  out  ID_W  ID dropped; valid only with evict_valid, else 0.

## Operation
- Queue: DEPTH slots of ID_W bits. Slot 0 is MRU. Occupied slots are contiguous from slot 0, and a non-zero ID appears at most once.
- Sampling: an internal tick is high for one cycle every TICK_DIV cycles. btn is sampled only on tick cycles.
- Winner: when several btn bits are high, the lowest index wins (b1 over b2 over …).
- FSM states:
  - IDLE → UPDATE on tick with btn≠0; latch winner ID W.
  - UPDATE (one cycle) → RELEASE; applies the queue update.
  - RELEASE → IDLE on tick with btn==0. Held buttons never cause a repeat push.
- Update rule for W:
  - W in slot j: slots 0..j-1 shift down one, W goes to slot 0, count unchanged, no eviction.
  - W absent, count<DEPTH: all slots shift down, W goes to slot 0, count+1.
  - W absent, count==DEPTH: slot DEPTH-1 is evicted (evict_valid=1, evict_id=old tail), remaining slots shift, W goes to slot 0.
  - W already in slot 0: queue unchanged, no eviction.
- Outputs led, mru_id, lru_id and count are combinational decodes of the queue register only, with no dependency on btn.

## Timing
- Reset: queue all 0, state IDLE, tick counter 0. led=0, mru_id=0, lru_id=0, count=0, evict_valid=0, evict_id=0.
- Tick: counter counts 0..TICK_DIV-1; tick=1 when counter==TICK_DIV-1, then the counter wraps to 0. With TICK_DIV=1, tick is constant 1.
- Latency: tick+press sampled in IDLE at cycle T, UPDATE at T+1, new queue and outputs visible at T+2. evict_valid is registered and high exactly in cycle T+2.
- btn changes during UPDATE are ignored; W is fixed at T.
- Reset mid-operation, in any state including UPDATE: the next cycle shows reset values and any in-flight push is discarded.
- Buttons released and re-pressed between ticks are invisible; only tick-cycle levels count.

## Structure
- Package lru_pkg holds:
  - state enum (IDLE, UPDATE, RELEASE);
  - the ID 0 empty constant;
  - helper function for the lowest-set-bit winner → ID.
- Sub-module lru_tick_gen (clk, rst, tick), parameter TICK_DIV, generates the sampling tick as a clock enable. No derived clocks.
- Queue shift/move-to-front is a generate loop over DEPTH inside lru_tracker.

## Test plan
All tests use N_CH=4, DEPTH=3, TICK_DIV=1.
- Reset with btn=4'b1111 held → all outputs 0. After rst falls, a push of ID1 occurs. Holding btn produces no further push.
- Press 1, 2, 3, each released in between → mru_id=3, lru_id=1, count=3, led=4'b0111, no evict_valid.
- Then press 4 → evict_valid pulses once with evict_id=1 at T+2. Queue becomes 4,3,2; led=4'b1110.
- Queue 4,3,2, press 2 → queue 2,4,3; count=3; no eviction; lru_id=3.
- btn=4'b1010 in one tick → ID2 pushed, not ID4. Press the MRU again → no change, no pulse.
- Assert rst during UPDATE → next cycle all outputs 0, no evict pulse. TICK_DIV=4 run: a push occurs only on every fourth cycle.
